// File: rtl/dac_spi_pkg.sv
// Shared definitions for the SPI DAC receiver: command codes, FSM states
// and frame width helper.
package dac_spi_pkg;

    localparam logic [3:0] CMD_WRITE        = 4'd0;
    localparam logic [3:0] CMD_UPDATE_ALL   = 4'd1;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'd2;
    localparam logic [3:0] CMD_CLEAR_ALL    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EXEC  = 2'd2
    } state_t;

    function automatic int frame_width(input int ctrl_w, input int data_w);
        return ctrl_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge (
    input  logic clk_sys,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    // sr[0..1] synchronize, sr[2] holds the previous synchronized value.
    // Resetting to 0 means a CS_ held low across reset never looks like a
    // fresh fall, so a frame interrupted by reset is ignored to its end.
    logic [2:0] sr;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sr <= 3'b000;
        end else begin
            sr <= {sr[1:0], din};
        end
    end

    assign dout = sr[1];
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_dac_receiver.sv
// SPI mode-0 front end for a multi-channel double-buffered DAC; SCK/SDI/CS_
// are oversampled in the Clk domain and frames are executed in one cycle.
//
//   state | meaning
//   IDLE  | waiting for CS_ fall
//   SHIFT | frame in progress, shifting SDI in and echo out on SDO
//   EXEC  | one cycle: decode and apply the received frame
module spi_dac_receiver
    import dac_spi_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8,
    parameter int NUM_CH = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     SCK,
    input  logic                     SDI,
    input  logic                     CS_,
    output logic                     SDO,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        update_pulse,
    output logic                     frame_err,
    output logic                     busy
);

    localparam int FRAME_W = frame_width(CTRL_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [4:0]       NUM_CH_L = 5'(NUM_CH);

    logic sck_rise, sck_fall, sck_level_unused;
    logic sdi_s, sdi_rise_unused, sdi_fall_unused;
    logic cs_rise, cs_fall, cs_level_unused;

    spi_sync_edge u_sync_sck (
        .clk_sys (Clk), .reset (Reset), .din (SCK),
        .dout (sck_level_unused), .rise (sck_rise), .fall (sck_fall)
    );
    spi_sync_edge u_sync_sdi (
        .clk_sys (Clk), .reset (Reset), .din (SDI),
        .dout (sdi_s), .rise (sdi_rise_unused), .fall (sdi_fall_unused)
    );
    spi_sync_edge u_sync_cs (
        .clk_sys (Clk), .reset (Reset), .din (CS_),
        .dout (cs_level_unused), .rise (cs_rise), .fall (cs_fall)
    );

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [FRAME_W-1:0]  frame_sr;
    logic [FRAME_W-1:0]  sdo_sr;
    logic [FRAME_W-1:0]  echo_reg;
    logic [DATA_W-1:0]   in_reg [NUM_CH];

    logic [3:0]          cmd;
    logic [3:0]          addr;
    logic [DATA_W-1:0]   data;
    logic                exec_err;

    assign cmd  = frame_sr[FRAME_W-1 -: 4];
    assign addr = frame_sr[DATA_W +: 4];
    assign data = frame_sr[DATA_W-1:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        exec_err  = 1'b0;
        case (state)
            IDLE:    if (cs_fall) state_nxt = SHIFT;
            SHIFT:   if (cs_rise) state_nxt = (bit_cnt == CNT_FULL) ? EXEC : IDLE;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (cmd > CMD_CLEAR_ALL) begin
            exec_err = 1'b1;
        end else if ((cmd == CMD_WRITE || cmd == CMD_WRITE_UPDATE) &&
                     ({1'b0, addr} >= NUM_CH_L)) begin
            exec_err = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bit_cnt      <= '0;
            frame_sr     <= '0;
            sdo_sr       <= '0;
            echo_reg     <= '0;
            ch_data      <= '0;
            update_pulse <= '0;
            frame_err    <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) in_reg[k] <= '0;
        end else begin
            update_pulse <= '0;
            frame_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        sdo_sr  <= echo_reg;
                    end
                end
                SHIFT: begin
                    // CS_ rise takes priority over any SCK edge in the same cycle
                    if (cs_rise) begin
                        if (bit_cnt != CNT_FULL) frame_err <= 1'b1;
                    end else begin
                        if (sck_rise) begin
                            frame_sr <= {frame_sr[FRAME_W-2:0], sdi_s};
                            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (sck_fall) sdo_sr <= {sdo_sr[FRAME_W-2:0], 1'b0};
                    end
                end
                EXEC: begin
                    echo_reg <= frame_sr;
                    if (exec_err) begin
                        frame_err <= 1'b1;
                    end else begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            case (cmd)
                                CMD_WRITE: begin
                                    if (addr == 4'(k)) in_reg[k] <= data;
                                end
                                CMD_UPDATE_ALL: begin
                                    ch_data[k*DATA_W +: DATA_W] <= in_reg[k];
                                    update_pulse[k]             <= 1'b1;
                                end
                                CMD_WRITE_UPDATE: begin
                                    if (addr == 4'(k)) begin
                                        in_reg[k]                   <= data;
                                        ch_data[k*DATA_W +: DATA_W] <= data;
                                        update_pulse[k]             <= 1'b1;
                                    end
                                end
                                CMD_CLEAR_ALL: begin
                                    in_reg[k]                   <= '0;
                                    ch_data[k*DATA_W +: DATA_W] <= '0;
                                    update_pulse[k]             <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign SDO  = (state == SHIFT) ? sdo_sr[FRAME_W-1] : 1'b0;
    assign busy = (state != IDLE);

endmodule
